// File: rtl/hsig_pkg.sv
// Shared definitions for hsig pad arbitration: FSM state encoding and the
// default levels of the pad controls that no owner ever drives.
package hsig_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN  = 2'd1,
    GAP  = 2'd2
  } hsig_state_e;

  localparam logic PAD_IE_DFLT = 1'b0;
  localparam logic PAD_SL_DFLT = 1'b0;
  localparam logic PAD_CS_DFLT = 1'b0;
  localparam logic PAD_PU_DFLT = 1'b0;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector: returns the first set req bit at or
// after rr_ptr, wrapping modulo N_REQ, as a one-hot vector plus a valid flag.
module rr_pick #(
  parameter  int N_REQ = 4,
  localparam int PW    = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic [N_REQ-1:0] req,
  input  logic [PW-1:0]    rr_ptr,
  output logic [N_REQ-1:0] pick,
  output logic             valid
);

  // Upper pass covers indices >= rr_ptr, lower pass handles the wrap.
  always_comb begin
    pick  = '0;
    valid = 1'b0;
    for (int j = 0; j < N_REQ; j++) begin
      if (!valid && req[j] && (PW'(j) >= rr_ptr)) begin
        pick[j] = 1'b1;
        valid   = 1'b1;
      end
    end
    for (int j = 0; j < N_REQ; j++) begin
      if (!valid && req[j] && (PW'(j) < rr_ptr)) begin
        pick[j] = 1'b1;
        valid   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/hsig_pad_arbiter.sv
// Round-robin owner of the shared hsig pad: bounded ownership slot when
// contended, and a driven-low guard gap between successive owners.
//
// state | meaning
// IDLE  | no owner; pad released, held low by pull-down
// OWN   | one requester drives hsig_A through the registered sig mux
// GAP   | pad actively driven low for GAP_CYCLES before next arbitration
module hsig_pad_arbiter
  import hsig_pkg::*;
#(
  parameter int N_REQ       = 4,
  parameter int SLOT_CYCLES = 256,
  parameter int GAP_CYCLES  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  input  logic [N_REQ-1:0] sig,
  output logic [N_REQ-1:0] grant,
  output logic             busy,
  output logic             hsig_A,
  output logic             hsig_OE,
  output logic             hsig_PD,
  output logic             hsig_IE,
  output logic             hsig_SL,
  output logic             hsig_CS,
  output logic             hsig_PU
);

  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int SW = $clog2(SLOT_CYCLES);
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  localparam logic [SW-1:0] SLOT_MAX = SW'(SLOT_CYCLES - 1);
  localparam logic [GW-1:0] GAP_MAX  = GW'(GAP_CYCLES - 1);
  localparam logic [PW-1:0] PTR_LAST = PW'(N_REQ - 1);

  hsig_state_e      state_q,   state_d;
  logic [N_REQ-1:0] grant_q,   grant_d;
  logic [PW-1:0]    owner_q,   owner_d;
  logic [PW-1:0]    rr_ptr_q,  rr_ptr_d;
  logic [SW-1:0]    slot_cnt_q, slot_cnt_d;
  logic [GW-1:0]    gap_cnt_q, gap_cnt_d;
  logic             hsig_a_q,  hsig_a_d;

  logic [N_REQ-1:0] pick;
  logic             pick_valid;
  logic [PW-1:0]    pick_idx;
  logic             owner_req;
  logic             other_req;
  logic             sig_owned;
  logic [PW-1:0]    ptr_after_owner;

  rr_pick #(.N_REQ(N_REQ)) u_rr_pick (
    .req    (req),
    .rr_ptr (rr_ptr_q),
    .pick   (pick),
    .valid  (pick_valid)
  );

  always_comb begin
    pick_idx = '0;
    for (int j = 0; j < N_REQ; j++) begin
      if (pick[j]) pick_idx = PW'(j);
    end
  end

  // AND-gating by grant keeps X on non-owner sig lines off the pad.
  assign sig_owned       = |(sig & grant_q);
  assign owner_req       = |(req & grant_q);
  assign other_req       = |(req & ~grant_q);
  assign ptr_after_owner = (owner_q == PTR_LAST) ? '0 : owner_q + PW'(1);

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    owner_d    = owner_q;
    rr_ptr_d   = rr_ptr_q;
    slot_cnt_d = slot_cnt_q;
    gap_cnt_d  = gap_cnt_q;
    hsig_a_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          state_d    = OWN;
          grant_d    = pick;
          owner_d    = pick_idx;
          slot_cnt_d = '0;
        end
      end
      OWN: begin
        if (!owner_req || ((slot_cnt_q == SLOT_MAX) && other_req)) begin
          state_d   = GAP;
          grant_d   = '0;
          rr_ptr_d  = ptr_after_owner;
          gap_cnt_d = '0;
        end else begin
          hsig_a_d = sig_owned;
          if (slot_cnt_q != SLOT_MAX) slot_cnt_d = slot_cnt_q + SW'(1);
        end
      end
      GAP: begin
        if (gap_cnt_q == GAP_MAX) begin
          if (pick_valid) begin
            state_d    = OWN;
            grant_d    = pick;
            owner_d    = pick_idx;
            slot_cnt_d = '0;
          end else begin
            state_d = IDLE;
          end
        end else begin
          gap_cnt_d = gap_cnt_q + GW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      owner_q    <= '0;
      rr_ptr_q   <= '0;
      slot_cnt_q <= '0;
      gap_cnt_q  <= '0;
      hsig_a_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      owner_q    <= owner_d;
      rr_ptr_q   <= rr_ptr_d;
      slot_cnt_q <= slot_cnt_d;
      gap_cnt_q  <= gap_cnt_d;
      hsig_a_q   <= hsig_a_d;
    end
  end

  assign grant   = grant_q;
  assign busy    = (state_q != IDLE);
  assign hsig_A  = hsig_a_q;
  assign hsig_OE = (state_q != IDLE);
  assign hsig_PD = (state_q == IDLE);
  assign hsig_IE = PAD_IE_DFLT;
  assign hsig_SL = PAD_SL_DFLT;
  assign hsig_CS = PAD_CS_DFLT;
  assign hsig_PU = PAD_PU_DFLT;

endmodule

// File: tb/tb_hsig_pad_arbiter.sv
// Scenario bench for hsig_pad_arbiter (N_REQ=4, SLOT_CYCLES=8, GAP_CYCLES=2):
// expected outputs are queued with each cycle's stimulus and checked after the edge.
module tb_hsig_pad_arbiter;

  typedef struct packed {
    logic [3:0] grant;
    logic       busy;
    logic       oe;
    logic       pd;
    logic       a;
  } exp_t;

  localparam exp_t E_IDLE = '{grant: 4'b0000, busy: 1'b0, oe: 1'b0, pd: 1'b1, a: 1'b0};
  localparam exp_t E_GAP  = '{grant: 4'b0000, busy: 1'b1, oe: 1'b1, pd: 1'b0, a: 1'b0};

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] req = '0;
  logic [3:0] sig = '0;
  logic [3:0] grant;
  logic       busy, hsig_A, hsig_OE, hsig_PD, hsig_IE, hsig_SL, hsig_CS, hsig_PU;

  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];

  hsig_pad_arbiter #(.N_REQ(4), .SLOT_CYCLES(8), .GAP_CYCLES(2)) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .sig     (sig),
    .grant   (grant),
    .busy    (busy),
    .hsig_A  (hsig_A),
    .hsig_OE (hsig_OE),
    .hsig_PD (hsig_PD),
    .hsig_IE (hsig_IE),
    .hsig_SL (hsig_SL),
    .hsig_CS (hsig_CS),
    .hsig_PU (hsig_PU)
  );

  always #5 clk = ~clk;

  function automatic exp_t e_own(int o, logic a);
    exp_t e;
    logic [3:0] g;
    g = 4'b0001 << o;
    e = '{grant: g, busy: 1'b1, oe: 1'b1, pd: 1'b0, a: a};
    return e;
  endfunction

  task automatic apply_reset();
    rst = 1'b1;
    req = '0;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    exp_t got, e;
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      if (k == 2) begin
        rst = 1'b0;
        req = '0;
      end else begin
        req = 4'($urandom);
        sig = 4'($urandom);
      end
      exp_q.push_back(E_IDLE);
      @(posedge clk); #1;
      got = '{grant: grant, busy: busy, oe: hsig_OE, pd: hsig_PD, a: hsig_A};
      e = exp_q.pop_front();
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL reset cyc %0d: got {grant,busy,oe,pd,a}=%b expected %b", k, got, e);
      end
      checks++;
      if ({hsig_IE, hsig_SL, hsig_CS, hsig_PU} !== 4'b0000) begin
        errors++;
        $display("FAIL pad_consts cyc %0d: got IE,SL,CS,PU=%b expected 0000", k,
                 {hsig_IE, hsig_SL, hsig_CS, hsig_PU});
      end
    end
  endtask

  task automatic test_single();
    exp_t got, e;
    logic s;
    apply_reset();
    for (int k = 0; k < 26; k++) begin
      s = 1'($urandom_range(0, 1));
      if (k < 23) begin
        req = 4'b0001;
        sig = {3'bxxx, s};
        e   = (k == 0) ? e_own(0, 1'b0) : e_own(0, s);
      end else begin
        req = 4'b0000;
        sig = 4'($urandom);
        e   = (k < 25) ? E_GAP : E_IDLE;
      end
      exp_q.push_back(e);
      @(posedge clk); #1;
      got = '{grant: grant, busy: busy, oe: hsig_OE, pd: hsig_PD, a: hsig_A};
      e = exp_q.pop_front();
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL single cyc %0d: got {grant,busy,oe,pd,a}=%b expected %b", k, got, e);
      end
    end
  endtask

  task automatic test_contention();
    exp_t got, e;
    int p, o;
    apply_reset();
    req = 4'b1111;
    for (int k = 0; k < 45; k++) begin
      sig = 4'($urandom);
      p = k % 10;
      o = (k / 10) % 4;
      if (p < 8) e = e_own(o, (p == 0) ? 1'b0 : sig[o]);
      else       e = E_GAP;
      exp_q.push_back(e);
      @(posedge clk); #1;
      got = '{grant: grant, busy: busy, oe: hsig_OE, pd: hsig_PD, a: hsig_A};
      e = exp_q.pop_front();
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL contention cyc %0d: got {grant,busy,oe,pd,a}=%b expected %b", k, got, e);
      end
    end
  endtask

  task automatic test_early_release();
    exp_t got, e;
    apply_reset();
    for (int k = 0; k < 9; k++) begin
      req = (k < 3) ? 4'b0100 : 4'b0010;
      sig = 4'($urandom);
      if (k == 0)      e = e_own(2, 1'b0);
      else if (k < 3)  e = e_own(2, sig[2]);
      else if (k < 5)  e = E_GAP;
      else if (k == 5) e = e_own(1, 1'b0);
      else             e = e_own(1, sig[1]);
      exp_q.push_back(e);
      @(posedge clk); #1;
      got = '{grant: grant, busy: busy, oe: hsig_OE, pd: hsig_PD, a: hsig_A};
      e = exp_q.pop_front();
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL early_release cyc %0d: got {grant,busy,oe,pd,a}=%b expected %b", k, got, e);
      end
    end
  endtask

  task automatic test_slot_boundary();
    exp_t got, e;
    apply_reset();
    for (int k = 0; k < 15; k++) begin
      if (k < 2)      req = 4'b0001;
      else if (k < 8) req = 4'b1001;
      else            req = 4'b1000;
      sig = 4'($urandom);
      if (k == 0)       e = e_own(0, 1'b0);
      else if (k < 8)   e = e_own(0, sig[0]);
      else if (k < 10)  e = E_GAP;
      else if (k == 10) e = e_own(3, 1'b0);
      else              e = e_own(3, sig[3]);
      exp_q.push_back(e);
      @(posedge clk); #1;
      got = '{grant: grant, busy: busy, oe: hsig_OE, pd: hsig_PD, a: hsig_A};
      e = exp_q.pop_front();
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL slot_boundary cyc %0d: got {grant,busy,oe,pd,a}=%b expected %b", k, got, e);
      end
    end
  endtask

  task automatic test_late_preempt();
    exp_t got, e;
    apply_reset();
    for (int k = 0; k < 17; k++) begin
      req = (k < 12) ? 4'b0001 : 4'b0011;
      sig = 4'($urandom);
      if (k == 0)       e = e_own(0, 1'b0);
      else if (k < 12)  e = e_own(0, sig[0]);
      else if (k < 14)  e = E_GAP;
      else if (k == 14) e = e_own(1, 1'b0);
      else              e = e_own(1, sig[1]);
      exp_q.push_back(e);
      @(posedge clk); #1;
      got = '{grant: grant, busy: busy, oe: hsig_OE, pd: hsig_PD, a: hsig_A};
      e = exp_q.pop_front();
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL late_preempt cyc %0d: got {grant,busy,oe,pd,a}=%b expected %b", k, got, e);
      end
    end
  endtask

  task automatic test_reset_mid_own();
    exp_t got, e;
    apply_reset();
    for (int k = 0; k < 9; k++) begin
      sig = 4'($urandom);
      if (k < 6) begin
        req = 4'b0001;
        e   = (k == 0) ? e_own(0, 1'b0) : e_own(0, sig[0]);
      end else if (k == 6) begin
        rst = 1'b1;
        e   = E_IDLE;
      end else begin
        rst = 1'b0;
        req = 4'b0100;
        e   = (k == 7) ? e_own(2, 1'b0) : e_own(2, sig[2]);
      end
      exp_q.push_back(e);
      @(posedge clk); #1;
      got = '{grant: grant, busy: busy, oe: hsig_OE, pd: hsig_PD, a: hsig_A};
      e = exp_q.pop_front();
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL reset_mid_own cyc %0d: got {grant,busy,oe,pd,a}=%b expected %b", k, got, e);
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    errors++;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_early_release();
    test_slot_boundary();
    test_late_preempt();
    test_reset_mid_own();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
